// File: rtl/ext_mem_capture_if.sv
// Pixel stream handshake into the frame capture block.
// master = upstream pixel source, slave = capture sink.
interface ext_mem_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/ext_mem_capture.sv
// Frame capture sink: stores a start-armed pixel stream into a 2**ADDR_W x DATA_W
// frame memory, with a registered read port for address-based readback.
module ext_mem_capture #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int FRAME_LEN = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    ext_mem_capture_if.slave  px,
    output logic              busy,
    output logic              done,
    output logic              frame_done,
    output logic              overflow,
    output logic [ADDR_W:0]   wr_count,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_e;

    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                fd_q, fd_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   rd_q;
    logic                accept;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    // in_ready comes straight from the state register, never from in_valid
    assign accept = (state_q == S_CAPTURE) && px.in_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        fd_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CAPTURE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        fd_d    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                // start wins over a same-cycle stray beat
                if (start) begin
                    state_d = S_CAPTURE;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (px.in_valid) begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            fd_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[addr_q] <= px.in_data;
        end
    end

    // Same-cycle read of the address being written returns the old byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
    end

    assign px.in_ready = (state_q == S_CAPTURE);
    assign busy        = (state_q == S_CAPTURE);
    assign done        = (state_q == S_DONE);
    assign frame_done  = fd_q;
    assign overflow    = ovf_q;
    assign wr_count    = cnt_q;
    assign rd_data     = rd_q;

endmodule

// File: tb/tb_ext_mem_capture.sv
// Bench: small-frame instance checked by a scoreboard against a behavioural
// model, plus a full 64K-frame instance streamed alongside it.
module tb_ext_mem_capture;

    localparam int FL = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_na, rst_nb, start_a, start_b, rd_en_a, rd_en_b;
    logic [15:0] rd_addr_a, rd_addr_b;
    logic        busy_a, done_a, fd_a, ovf_a;
    logic        busy_b, done_b, fd_b, ovf_b;
    logic [16:0] wr_count_a, wr_count_b;
    logic [7:0]  rd_data_a, rd_data_b;

    ext_mem_capture_if #(.DATA_W(8)) ifa ();
    ext_mem_capture_if #(.DATA_W(8)) ifb ();

    ext_mem_capture #(.DATA_W(8), .ADDR_W(16), .FRAME_LEN(FL)) dut_a (
        .clk(clk), .rst_n(rst_na), .start(start_a), .px(ifa),
        .busy(busy_a), .done(done_a), .frame_done(fd_a),
        .overflow(ovf_a), .wr_count(wr_count_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a)
    );

    ext_mem_capture #(.DATA_W(8), .ADDR_W(16), .FRAME_LEN(65536)) dut_b (
        .clk(clk), .rst_n(rst_nb), .start(start_b), .px(ifb),
        .busy(busy_b), .done(done_b), .frame_done(fd_b),
        .overflow(ovf_b), .wr_count(wr_count_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b)
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit         rdy;
        bit         bsy;
        bit         dn;
        bit         fd;
        bit         ovf;
        int         cnt;
        logic [7:0] rd;
    } exp_t;

    exp_t q[$];

    bit         m_cap, m_done, m_ovf;
    int         m_cnt;
    logic [7:0] m_rd;
    logic [7:0] mm [FL];
    bit         known [FL];

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void push_exp(input bit fd);
        exp_t e;
        e.rdy = m_cap;
        e.bsy = m_cap;
        e.dn  = m_done;
        e.fd  = fd;
        e.ovf = m_ovf;
        e.cnt = m_cnt;
        e.rd  = m_rd;
        q.push_back(e);
    endfunction

    task automatic step(input bit s, input bit v, input logic [7:0] d,
                        input bit re, input int ra);
        bit fd;
        bit r;
        fd = 1'b0;
        r  = re && known[ra % FL];
        @(negedge clk);
        #1;
        rst_na       = 1'b1;
        start_a      = s;
        ifa.in_valid = v;
        ifa.in_data  = d;
        rd_en_a      = r;
        rd_addr_a    = 16'(ra % FL);
        if (r) m_rd = mm[ra % FL];
        if (m_cap && v) begin
            mm[m_cnt]    = d;
            known[m_cnt] = 1'b1;
            m_cnt++;
            if (m_cnt == FL) begin
                m_cap  = 1'b0;
                m_done = 1'b1;
                fd     = 1'b1;
            end
        end else if (!m_cap && s) begin
            m_cap  = 1'b1;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 0;
        end else if (m_done && v) begin
            m_ovf = 1'b1;
        end
        push_exp(fd);
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            rst_na       = 1'b0;
            start_a      = 1'b0;
            ifa.in_valid = 1'b0;
            rd_en_a      = 1'b0;
            m_cap  = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_cnt  = 0;
            m_rd   = 8'h00;
            push_exp(1'b0);
        end
    endtask

    // Monitor: one expected status per cycle, compared away from the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("a_in_ready", 32'(ifa.in_ready), 32'(e.rdy));
                chk("a_busy",     32'(busy_a),       32'(e.bsy));
                chk("a_done",     32'(done_a),       32'(e.dn));
                chk("a_frame_done", 32'(fd_a),       32'(e.fd));
                chk("a_overflow", 32'(ovf_a),        32'(e.ovf));
                chk("a_wr_count", 32'(wr_count_a),   32'(e.cnt));
                chk("a_rd_data",  32'(rd_data_a),    32'(e.rd));
            end
        end
    end

    task automatic run_small();
        int idx;
        reset_cycles(2);
        step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < FL; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 0);
        repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < FL; i++) step(1'b0, 1'b0, 8'h00, 1'b1, i);
        step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        // toggling valid
        step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        idx = 0;
        for (int k = 0; k < 31; k++) begin
            if (k % 2 == 0) begin
                step(1'b0, 1'b1, 8'(8'h10 + idx), 1'b0, 0);
                idx++;
            end else begin
                step(1'b0, 1'b0, 8'h77, 1'b0, 0);
            end
        end
        // overflow while done, then start with a stray beat
        repeat (3) step(1'b0, 1'b1, 8'hAA, 1'b0, 0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        step(1'b1, 1'b1, 8'hAA, 1'b0, 0);
        // partial frame then reset
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 0);
        reset_cycles(2);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, i);
        step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        // read-before-write on address 3
        step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        for (int i = 0; i < FL; i++) begin
            step(1'b0, 1'b1, (i == 3) ? 8'h5A : 8'(8'h20 + i), i == 3, 3);
        end
        step(1'b0, 1'b0, 8'h00, 1'b1, 3);
        step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                 8'($urandom), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, FL - 1)));
        end
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        repeat (2) @(negedge clk);
        chk("a_scoreboard_drain", 32'(q.size()), 32'd0);
    endtask

    task automatic run_big();
        int fdn;
        fdn = 0;
        repeat (2) @(negedge clk);
        #1 rst_nb = 1'b1;
        @(negedge clk);
        #1 start_b = 1'b1;
        @(negedge clk);
        #1 start_b = 1'b0;
        chk("b_ready_after_start", 32'(ifb.in_ready), 32'd1);
        for (int i = 0; i < 65536; i++) begin
            ifb.in_valid = 1'b1;
            ifb.in_data  = 8'(i);
            @(negedge clk);
            fdn += int'(fd_b);
            #1;
        end
        ifb.in_valid = 1'b0;
        chk("b_frame_done", 32'(fd_b), 32'd1);
        chk("b_frame_done_count", 32'(fdn), 32'd1);
        chk("b_wr_count", 32'(wr_count_b), 32'd65536);
        chk("b_done", 32'(done_b), 32'd1);
        chk("b_in_ready", 32'(ifb.in_ready), 32'd0);
        rd_en_b   = 1'b1;
        rd_addr_b = 16'hFFFF;
        @(negedge clk);
        #1;
        chk("b_mem_65535", 32'(rd_data_b), 32'hFF);
        rd_addr_b = 16'd256;
        @(negedge clk);
        #1;
        chk("b_mem_256", 32'(rd_data_b), 32'h00);
        rd_addr_b = 16'd1000;
        @(negedge clk);
        #1;
        chk("b_mem_1000", 32'(rd_data_b), 32'hE8);
        rd_en_b = 1'b0;
        @(negedge clk);
        chk("b_rd_hold", 32'(rd_data_b), 32'hE8);
        chk("b_overflow", 32'(ovf_b), 32'd0);
        chk("b_frame_done_clear", 32'(fd_b), 32'd0);
    endtask

    initial begin
        rst_na = 1'b0;
        rst_nb = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        ifa.in_valid = 1'b0;
        ifa.in_data  = '0;
        ifb.in_valid = 1'b0;
        ifb.in_data  = '0;
        m_cap = 1'b0;
        m_done = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
        m_rd = 8'h00;
        for (int i = 0; i < FL; i++) begin
            mm[i] = 8'h00;
            known[i] = 1'b0;
        end
        fork
            run_small();
            run_big();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
